// File: rtl/alu_reg_sequencer.sv
// Command sequencer for the two-register add/sub datapath: expands one opcode into 1 or 3 control steps.
// Optional build macro ALU_SEQ_CARRY_FLAG_EN adds a sticky per-command carry_flag output.
module alu_reg_sequencer #(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [BIT_WIDTH-1:0] cmd_data,
    input  logic                 alu_cout,
    output logic                 s_reg,
    output logic                 en_ra,
    output logic                 en_rb,
    output logic                 s,
    output logic [BIT_WIDTH-1:0] alu_in,
`ifdef ALU_SEQ_CARRY_FLAG_EN
    output logic                 carry_flag,
`endif
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, STEP1, STEP2, STEP3} state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_SUBB = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    state_t                 state_reg, state_next;
    logic [2:0]             op_reg;
    logic [BIT_WIDTH-1:0]   data_reg;
    logic                   done_reg, done_next;
    logic                   err_reg, err_next;
    logic                   accept;
    logic                   load_step;

    assign cmd_ready = (state_reg == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = done_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_NOP;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (accept) begin
                op_reg   <= cmd_op;
                data_reg <= cmd_data;
            end
        end
    end

    // Next state, completion strobes and Moore control decode from state + latched op.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        s_reg      = 1'b0;
        en_ra      = 1'b0;
        en_rb      = 1'b0;
        s          = 1'b0;
        load_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = STEP1;
            end
            STEP1: begin
                if (op_reg == OP_SWAP) begin
                    state_next = STEP2;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    err_next   = (op_reg == OP_ILL);
                end
                case (op_reg)
                    OP_LDA:  begin s_reg = 1'b1; en_ra = 1'b1; load_step = 1'b1; end
                    OP_LDB:  begin s_reg = 1'b1; en_rb = 1'b1; load_step = 1'b1; end
                    OP_ADD:  begin en_ra = 1'b1; end
                    OP_SUB:  begin en_ra = 1'b1; s = 1'b1; end
                    OP_SWAP: begin en_ra = 1'b1; end
                    OP_SUBB: begin en_rb = 1'b1; s = 1'b1; end
                    default: ;
                endcase
            end
            STEP2: begin
                state_next = STEP3;
                en_rb      = 1'b1;
                s          = 1'b1;
            end
            STEP3: begin
                state_next = IDLE;
                done_next  = 1'b1;
                en_ra      = 1'b1;
                s          = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // External data only reaches the datapath during a load step.
    generate
        for (genvar gi = 0; gi < BIT_WIDTH; gi++) begin : g_alu_in
            assign alu_in[gi] = data_reg[gi] & load_step;
        end
    endgenerate

`ifdef ALU_SEQ_CARRY_FLAG_EN
    logic carry_reg;
    assign carry_flag = carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
        end else if (accept) begin
            carry_reg <= 1'b0;
        end else if (!s_reg && (en_ra || en_rb) && alu_cout) begin
            carry_reg <= 1'b1;
        end
    end
`else
    logic unused_cout;
    assign unused_cout = alu_cout;
`endif

endmodule

// File: doc/alu_reg_sequencer.md
Name: alu_reg_sequencer

Overview:
Command-level controller for the two-register ALU datapath (registers A and B, 2:1 input mux, add/sub ALU). It accepts one opcode plus data word per valid/ready handshake. It expands the opcode into one or three cycles of datapath control (s_reg, en_ra, en_rb, s, alu_in) and pulses done when the command completes. It sits between the instruction/test front end and the ALU-with-register datapath.

Parameters:
BIT_WIDTH, 4, width of data word, alu_in and datapath registers

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  opcode
cmd_data  input  BIT_WIDTH  load data (used by LDA/LDB)
alu_cout  input  1  carry out from datapath ALU
s_reg  output  1  datapath mux select: 1 = external alu_in, 0 = ALU result
en_ra  output  1  register A write enable
en_rb  output  1  register B write enable
s  output  1  ALU op: 0 = A+B, 1 = A-B
alu_in  output  BIT_WIDTH  data to datapath external input
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse, with done, for illegal opcode

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst). All state is updated on rising clk.
- Reset values: state=IDLE; cmd_ready=1; s_reg=en_ra=en_rb=s=0; alu_in=0; done=err=0.
- FSM states: IDLE, STEP1, STEP2, STEP3.
- cmd_ready = (state==IDLE). A command is accepted on an edge where cmd_valid && cmd_ready. At acceptance, cmd_op and cmd_data are latched.
- Transitions:
  - IDLE -> STEP1 on accept.
  - STEP1 -> STEP2 if the op is SWAP, else -> IDLE.
  - STEP2 -> STEP3.
  - STEP3 -> IDLE.
- Opcodes and per-step controls (outputs are Moore, decoded from state and latched op):
  - 000 NOP: STEP1 has all enables 0.
  - 001 LDA: s_reg=1, en_ra=1, alu_in=data.
  - 010 LDB: s_reg=1, en_rb=1, alu_in=data.
  - 011 ADD: s_reg=0, en_ra=1, s=0 (A<=A+B).
  - 100 SUB: s_reg=0, en_ra=1, s=1 (A<=A-B).
  - 101 SWAP: STEP1 en_ra=1 s=0; STEP2 en_rb=1 s=1; STEP3 en_ra=1 s=1. s_reg=0 in all three steps.
  - 110 SUBB: s_reg=0, en_rb=1, s=1 (B<=A-B).
  - 111 illegal: STEP1 has all enables 0; err pulses with done.
- Outside STEPn, all control outputs are 0 and alu_in=0. alu_in is 0 in every non-load step.
- Latency:
  - Single-step ops: accept at edge t; control active in cycle t..t+1; done=1 in the cycle after the final step. In that same cycle cmd_ready=1.
  - SWAP: 3 control cycles, then done.
  - Back-to-back throughput: one single-step command per 2 cycles. No command is accepted while busy.
- done and err are registered, high for exactly one cycle, and never asserted without a preceding accept.
- cmd_valid while busy: ignored and held off by cmd_ready=0. The requester must hold cmd_valid, cmd_op and cmd_data stable until accepted.
- Reset mid-command: the next cycle is IDLE with all outputs 0. The command is aborted and no done/err is issued.
- Arithmetic is performed in the datapath, modulo 2^BIT_WIDTH. The sequencer does not compute data.

Optional Feature:
Macro ALU_SEQ_CARRY_FLAG_EN.
- Defined: adds output carry_flag (1 bit, reset 0).
  - carry_flag clears on command accept.
  - It is set if alu_cout==1 at the end of any step with s_reg=0 and (en_ra|en_rb) within that command.
  - It is valid from the done cycle and holds until the next accept.
- Undefined: carry_flag port and logic are absent. alu_cout is unused.

Test Plan:
- The bench uses a behavioural datapath model (A, B registers, add/sub, cout).
- Reset: assert rst for 2 cycles -> cmd_ready=1, all controls 0, done=0. Assert rst during SWAP STEP2 -> IDLE next cycle, no done.
- LDA 4, then LDB 3 -> A=4, B=3. Each load has exactly one enable cycle with s_reg=1 and alu_in equal to the data. done pulses 1 cycle after each.
- SWAP with A=4, B=3 -> control sequence (en_ra,en_rb,s) = 100, 011, 101 with s_reg=0. Final A=3, B=4. done arrives 4 cycles after accept.
- ADD with A=9, B=9 (BIT_WIDTH=4) -> A=2. With the macro, carry_flag=1. A following SUB with A=2, B=1 -> A=1 and carry_flag cleared at accept.
- Opcode 111 -> no enables asserted; done=1 and err=1 in the same single cycle.
- cmd_valid held high continuously during SWAP -> exactly one accept. The next command is accepted only in the done/IDLE cycle.
